// File: rtl/maroc_sc_pkg.sv
// Shared definitions for the MAROC slow-control chain: chain length, field offsets, sequencer states.
package maroc_sc_pkg;

  localparam int SC_LEN = 829;

  localparam int OFS_DAC2       = 3;
  localparam int OFS_DAC1       = 13;
  localparam int OFS_MASK_OR_CH = 27;
  localparam int OFS_GAIN       = 189;
  localparam int OFS_CTEST_CH   = 765;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHIPRST = 3'd1,
    LOAD    = 3'd2,
    VERIFY  = 3'd3,
    CHECK   = 3'd4,
    FINISH  = 3'd5
  } sc_state_e;

endpackage

// File: rtl/sc_clk_gen.sv
// Serial clock generator: each slot is CLK_DIV cycles low then CLK_DIV cycles high, with
// a sample strobe in the last low cycle and an end strobe in the last cycle of the slot.
module sc_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic act,
  input  logic act_nx,
  output logic sc_ck,
  output logic sample_pt,
  output logic slot_end
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] PH_LOW_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HIGH     = PW'(CLK_DIV);
  localparam logic [PW-1:0] PH_LAST     = PW'(2 * CLK_DIV - 1);

  logic [PW-1:0] ph_r;
  logic [PW-1:0] ph_nx_s;
  logic          sc_ck_r;

  // next slot phase; phase is parked at 0 outside shifting states
  always_comb begin
    ph_nx_s = '0;
    if (!act) begin
      ph_nx_s = '0;
    end else if (ph_r == PH_LAST) begin
      ph_nx_s = '0;
    end else begin
      ph_nx_s = ph_r + PW'(1);
    end
  end

  // phase counter and glitch-free registered serial clock
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_r    <= '0;
      sc_ck_r <= 1'b0;
    end else begin
      ph_r    <= ph_nx_s;
      sc_ck_r <= act_nx && (ph_nx_s >= PH_HIGH);
    end
  end

  assign sc_ck     = sc_ck_r;
  assign sample_pt = act && (ph_r == PH_LOW_LAST);
  assign slot_end  = act && (ph_r == PH_LAST);

endmodule

// File: rtl/maroc_sc_sequencer.sv
// MAROC slow-control load sequencer: chip reset, serial load, optional readback verify with retries.
// Readback/retry logic is compiled in only when MAROC_SC_VERIFY_EN is defined.
module maroc_sc_sequencer #(
  parameter int SC_LEN  = maroc_sc_pkg::SC_LEN,
  parameter int CLK_DIV = 4,
  parameter int RST_CYC = 8
) (
  input  logic       CK_SC,
  input  logic       rst,
  input  logic       start,
  input  logic       verify_en,
  input  logic [1:0] max_retry,
  output logic [9:0] cfg_idx,
  input  logic       cfg_bit,
  output logic       sc_ck,
  output logic       sc_d,
  output logic       sc_rstb,
  input  logic       sc_q,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] retries,
  output logic [9:0] mismatch_cnt
);
  import maroc_sc_pkg::*;

  localparam int RCW = $clog2(RST_CYC + 1);
  localparam logic [RCW-1:0] RC_LAST  = RCW'(RST_CYC - 1);
  localparam logic [9:0]     IDX_LAST = 10'(SC_LEN - 1);

  sc_state_e      state_r;
  sc_state_e      state_nx_s;
  logic [RCW-1:0] rcnt_r;
  logic [9:0]     idx_r;
  logic           busy_r;
  logic           done_r;
  logic           rstb_r;
  logic           slot_act_s;
  logic           slot_act_nx_s;
  logic           sample_pt_s;
  logic           slot_end_s;
  logic           last_slot_s;

`ifdef MAROC_SC_VERIFY_EN
  logic           vfy_r;
  logic [1:0]     maxr_r;
  logic           err_r;
  logic [1:0]     retr_r;
  logic [9:0]     mm_r;
`endif

  assign slot_act_s    = (state_r == LOAD) || (state_r == VERIFY);
  assign slot_act_nx_s = (state_nx_s == LOAD) || (state_nx_s == VERIFY);
  assign last_slot_s   = (idx_r == IDX_LAST);

  sc_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk       (CK_SC),
    .rst       (rst),
    .act       (slot_act_s),
    .act_nx    (slot_act_nx_s),
    .sc_ck     (sc_ck),
    .sample_pt (sample_pt_s),
    .slot_end  (slot_end_s)
  );

  // next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = CHIPRST;
        else       state_nx_s = IDLE;
      end
      CHIPRST: begin
        if (rcnt_r == RC_LAST) state_nx_s = LOAD;
        else                   state_nx_s = CHIPRST;
      end
      LOAD: begin
        if (slot_end_s && last_slot_s) begin
`ifdef MAROC_SC_VERIFY_EN
          if (vfy_r) state_nx_s = VERIFY;
          else       state_nx_s = FINISH;
`else
          state_nx_s = FINISH;
`endif
        end else begin
          state_nx_s = LOAD;
        end
      end
`ifdef MAROC_SC_VERIFY_EN
      VERIFY: begin
        if (slot_end_s && last_slot_s) state_nx_s = CHECK;
        else                           state_nx_s = VERIFY;
      end
      CHECK: begin
        if (mm_r == 10'd0)          state_nx_s = FINISH;
        else if (retr_r < maxr_r)   state_nx_s = CHIPRST;
        else                        state_nx_s = FINISH;
      end
`endif
      FINISH:  state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // state register; status outputs are registered from the next state so they align with it
  always_ff @(posedge CK_SC) begin
    if (rst) begin
      state_r <= IDLE;
      rcnt_r  <= '0;
      idx_r   <= 10'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rstb_r  <= 1'b1;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != IDLE) && (state_nx_s != FINISH);
      done_r  <= (state_nx_s == FINISH);
      rstb_r  <= (state_nx_s != CHIPRST);
      rcnt_r  <= (state_r == CHIPRST) ? rcnt_r + RCW'(1) : '0;
      if (slot_end_s) begin
        idx_r <= last_slot_s ? 10'd0 : idx_r + 10'd1;
      end
    end
  end

`ifdef MAROC_SC_VERIFY_EN
  // per-sequence options, readback mismatch counting and retry bookkeeping
  always_ff @(posedge CK_SC) begin
    if (rst) begin
      vfy_r  <= 1'b0;
      maxr_r <= 2'd0;
      err_r  <= 1'b0;
      retr_r <= 2'd0;
      mm_r   <= 10'd0;
    end else if ((state_r == IDLE) && start) begin
      vfy_r  <= verify_en;
      maxr_r <= max_retry;
      err_r  <= 1'b0;
      retr_r <= 2'd0;
      mm_r   <= 10'd0;
    end else if (state_r == CHECK) begin
      if (mm_r != 10'd0) begin
        if (retr_r < maxr_r) begin
          retr_r <= retr_r + 2'd1;
          mm_r   <= 10'd0;
        end else begin
          err_r <= 1'b1;
        end
      end
    end else if ((state_r == VERIFY) && sample_pt_s && (sc_q != cfg_bit)) begin
      mm_r <= mm_r + 10'd1;
    end
  end

  assign err          = err_r;
  assign retries      = retr_r;
  assign mismatch_cnt = mm_r;
`else
  logic unused_s;
  assign unused_s     = ^{verify_en, max_retry, sc_q, sample_pt_s};
  assign err          = 1'b0;
  assign retries      = 2'd0;
  assign mismatch_cnt = 10'd0;
`endif

  // cfg_bit follows cfg_idx combinationally, so passing it through keeps sc_d aligned to the slot
  assign sc_d    = slot_act_s & cfg_bit;
  assign cfg_idx = idx_r;
  assign sc_rstb = rstb_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_maroc_sc_sequencer.sv
// Directed bench for maroc_sc_sequencer with a shift-register chip model on sc_ck.
module tb_maroc_sc_sequencer;

  localparam int N        = maroc_sc_pkg::SC_LEN;
  localparam int DIV      = 4;
  localparam int RC       = 8;
  localparam int LOAD_LAT = 1 + RC + N * 2 * DIV;         // 6641
  localparam int PASS     = RC + 2 * (N * 2 * DIV) + 1;   // 13273 incl. CHECK

  logic       CK_SC = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       verify_en = 1'b0;
  logic [1:0] max_retry = 2'd0;
  logic [9:0] cfg_idx;
  logic       cfg_bit;
  logic       sc_ck;
  logic       sc_d;
  logic       sc_rstb;
  logic       sc_q;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] retries;
  logic [9:0] mismatch_cnt;

  logic [N-1:0] pat = '0;
  logic [N-1:0] chain = '0;
  int since_rst = 0;
  int rises = 0;
  int rstb_falls = 0;
  int done_cnt = 0;
  int fault_mode = 0;
  int fault_base = 0;
  int r0, f0, d0;
  int n_chk = 0;
  int n_pass = 0;
  logic fault_s;

  maroc_sc_sequencer dut (
    .CK_SC        (CK_SC),
    .rst          (rst),
    .start        (start),
    .verify_en    (verify_en),
    .max_retry    (max_retry),
    .cfg_idx      (cfg_idx),
    .cfg_bit      (cfg_bit),
    .sc_ck        (sc_ck),
    .sc_d         (sc_d),
    .sc_rstb      (sc_rstb),
    .sc_q         (sc_q),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .retries      (retries),
    .mismatch_cnt (mismatch_cnt)
  );

  always #5 CK_SC = ~CK_SC;

  assign cfg_bit = (cfg_idx < 10'(N)) ? pat[cfg_idx] : 1'b0;

  // chip model: chain shifts on sc_ck rising, sc_q is the far end
  always @(posedge sc_ck) chain <= {chain[N-2:0], sc_d};
  always @(posedge sc_ck) rises <= rises + 1;
  always @(posedge sc_ck or negedge sc_rstb) begin
    if (!sc_rstb) since_rst <= 0;
    else          since_rst <= since_rst + 1;
  end
  always @(negedge sc_rstb) rstb_falls <= rstb_falls + 1;
  always @(posedge CK_SC) if (done) done_cnt <= done_cnt + 1;

  // fault: bit 100 reads back as 0 during a readback pass (mode 1 always, mode 2 first pass only)
  assign fault_s = (fault_mode != 0) && (since_rst >= N) && (cfg_idx == 10'd100) &&
                   ((fault_mode == 1) || (rstb_falls == fault_base + 1));
  assign sc_q = fault_s ? 1'b0 : chain[N-1];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic fill_pat();
    for (int i = 0; i < N; i++) pat[i] = 1'($urandom_range(0, 1));
    pat[100] = 1'b1;
  endtask

  task automatic check_chain(input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++) if (chain[N-1-i] !== pat[i]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_sc_ck"}, 32'(sc_ck), 32'd0);
    chk({tag, "_sc_d"}, 32'(sc_d), 32'd0);
    chk({tag, "_sc_rstb"}, 32'(sc_rstb), 32'd1);
    chk({tag, "_cfg_idx"}, 32'(cfg_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_retries"}, 32'(retries), 32'd0);
    chk({tag, "_mismatch"}, 32'(mismatch_cnt), 32'd0);
  endtask

  // start one sequence, optionally re-pulse start every 100 cycles while it runs
  task automatic run_seq(input logic ve, input logic [1:0] mr, input bit spam,
                         input int exp_cyc, input string tag);
    int n;
    r0 = rises;
    f0 = rstb_falls;
    d0 = done_cnt;
    verify_en = ve;
    max_retry = mr;
    start = 1'b1;
    @(posedge CK_SC); #1;
    start = 1'b0;
    n = 1;
    chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
    chk({tag, "_rstb_c1"}, 32'(sc_rstb), 32'd0);
    while (!done && n < exp_cyc + 100) begin
      if (spam && (n % 100 == 0)) start = 1'b1;
      else                        start = 1'b0;
      @(posedge CK_SC); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, 32'(n), 32'(exp_cyc));
  endtask

  initial begin
    int n;
    fill_pat();
    start = 1'b1;
    repeat (3) @(posedge CK_SC);
    #1;
    check_reset("reset");
    rst = 1'b0;
    start = 1'b0;
    @(posedge CK_SC); #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // abort mid-load at cfg_idx 400
    start = 1'b1;
    @(posedge CK_SC); #1;
    start = 1'b0;
    n = 1;
    while (!(cfg_idx == 10'd400 && busy && sc_rstb) && n < 5000) begin
      @(posedge CK_SC); #1;
      n++;
    end
    chk("abort_reach_idx400", 32'(n), 32'(1 + RC + 400 * 2 * DIV));
    rst = 1'b1;
    @(posedge CK_SC); #1;
    check_reset("abort");
    r0 = rises;
    repeat (4) @(posedge CK_SC);
    #1;
    chk("abort_no_sc_ck", 32'(rises - r0), 32'd0);
    rst = 1'b0;
    @(posedge CK_SC); #1;

    // full load, start spammed while busy
    fill_pat();
    run_seq(1'b0, 2'd0, 1'b1, LOAD_LAT, "load");
    chk("load_rises", 32'(rises - r0), 32'(N));
    chk("load_rstb_pulses", 32'(rstb_falls - f0), 32'd1);
    chk("load_err", 32'(err), 32'd0);
    chk("load_idx_after", 32'(cfg_idx), 32'd0);
    check_chain("load_contents");
    repeat (300) @(posedge CK_SC);
    #1;
    chk("load_single_done", 32'(done_cnt - d0), 32'd1);
    chk("load_busy_after", 32'(busy), 32'd0);

`ifdef MAROC_SC_VERIFY_EN
    fill_pat();
    run_seq(1'b1, 2'd0, 1'b0, 1 + PASS, "vfy_ok");
    chk("vfy_ok_rises", 32'(rises - r0), 32'(2 * N));
    chk("vfy_ok_mismatch", 32'(mismatch_cnt), 32'd0);
    chk("vfy_ok_err", 32'(err), 32'd0);
    chk("vfy_ok_retries", 32'(retries), 32'd0);
    chk("vfy_ok_rstb_pulses", 32'(rstb_falls - f0), 32'd1);
    @(posedge CK_SC); #1;

    fill_pat();
    fault_mode = 1;
    fault_base = rstb_falls;
    run_seq(1'b1, 2'd2, 1'b0, 1 + 3 * PASS, "vfy_fail");
    chk("vfy_fail_mismatch", 32'(mismatch_cnt), 32'd1);
    chk("vfy_fail_retries", 32'(retries), 32'd2);
    chk("vfy_fail_err", 32'(err), 32'd1);
    chk("vfy_fail_rstb_pulses", 32'(rstb_falls - f0), 32'd3);
    repeat (5) @(posedge CK_SC);
    #1;
    chk("err_hold", 32'(err), 32'd1);
    chk("retries_hold", 32'(retries), 32'd2);

    fault_mode = 2;
    fault_base = rstb_falls;
    run_seq(1'b1, 2'd2, 1'b0, 1 + 2 * PASS, "vfy_retry1");
    chk("vfy_retry1_retries", 32'(retries), 32'd1);
    chk("vfy_retry1_err", 32'(err), 32'd0);
    chk("vfy_retry1_mismatch", 32'(mismatch_cnt), 32'd0);
    chk("vfy_retry1_rstb_pulses", 32'(rstb_falls - f0), 32'd2);
    fault_mode = 0;
`else
    fill_pat();
    fault_mode = 1;
    fault_base = rstb_falls;
    run_seq(1'b1, 2'd3, 1'b0, LOAD_LAT, "novfy");
    chk("novfy_rises", 32'(rises - r0), 32'(N));
    chk("novfy_err", 32'(err), 32'd0);
    chk("novfy_retries", 32'(retries), 32'd0);
    chk("novfy_mismatch", 32'(mismatch_cnt), 32'd0);
    chk("novfy_rstb_pulses", 32'(rstb_falls - f0), 32'd1);
    check_chain("novfy_contents");
    fault_mode = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
